// File: rtl/pipe_ifq.sv
// pipe_ifq: instruction prefetch queue between a synchronous instruction
// memory and the IF/ID register. Owns the fetch PC, keeps at most one read
// outstanding, buffers {inst, pc+4} in a DEPTH-entry circular queue and
// presents the oldest entry. A redirect flushes the queue and restarts fetch.
//
// Optional feature: define IFQ_BYPASS_EN to forward a response straight to
// out_* when the queue is empty (one cycle lower fetch-to-output latency).
module pipe_ifq #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          deq,
    output logic          out_valid,
    output logic [31:0]   out_inst,
    output logic [31:0]   out_pc4,
    output logic [AW:0]   count
);

    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    // Request stage (p0) state
    logic [31:0]   fetch_pc;

    // Response stage (p1): the read issued last cycle returns now
    logic          vld_p1;
    logic          kill_p1;
    logic [31:0]   pc4_p1;

    // Queue storage and control
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc4_q  [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count_q;

    logic          push;
    logic          pop;
    logic          wr;
    logic          rd;
    logic [AW+1:0] occ_next;

    // Head presentation; with bypass an arriving response is shown when empty
    always_comb begin
        out_valid = (count_q != '0);
        out_inst  = out_valid ? inst_q[head] : 32'h0;
        out_pc4   = out_valid ? pc4_q[head]  : 32'h0;
`ifdef IFQ_BYPASS_EN
        if ((count_q == '0) && push) begin
            out_valid = 1'b1;
            out_inst  = imem_rdata;
            out_pc4   = pc4_p1;
        end
`endif
    end

    // Push/pop decode and request admission based on next-cycle occupancy
    always_comb begin
        push = vld_p1 & ~kill_p1 & ~redirect & ~reset;
        pop  = deq & out_valid & ~redirect & ~reset;
`ifdef IFQ_BYPASS_EN
        // A bypassed response consumed in the same cycle never touches storage
        wr = push & ~((count_q == '0) & deq);
        rd = pop & (count_q != '0);
`else
        wr = push;
        rd = pop;
`endif
        occ_next  = {1'b0, count_q} + (AW+2)'(push) - (AW+2)'(pop);
        imem_req  = ~reset & ~redirect & (occ_next < DEPTH_W);
        imem_addr = fetch_pc;
        count     = count_q;
    end

    // Control state: fetch PC, in-flight tracking, queue pointers and count
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= 32'h0;
            vld_p1   <= 1'b0;
            kill_p1  <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            vld_p1   <= 1'b0;
            kill_p1  <= 1'b1;
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
        end else begin
            if (imem_req) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            vld_p1  <= imem_req;
            kill_p1 <= 1'b0;
            if (wr) begin
                tail <= tail + 1'b1;
            end
            if (rd) begin
                head <= head + 1'b1;
            end
            count_q <= count_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    // Datapath registers: response PC+4 and queue contents (not reset)
    always_ff @(posedge clock) begin
        if (imem_req) begin
            pc4_p1 <= fetch_pc + 32'd4;
        end
        if (wr) begin
            inst_q[tail] <= imem_rdata;
            pc4_q[tail]  <= pc4_p1;
        end
    end

endmodule

// File: tb/tb_pipe_ifq.sv
// tb_pipe_ifq: directed table of per-cycle vectors for pipe_ifq (default
// build, no bypass), plus a hand-written redirect latency sequence.
module tb_pipe_ifq;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clock;
    logic          reset;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          deq;
    logic          out_valid;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc4;
    logic [AW:0]   count;

    int n_chk;
    int n_fail;

    pipe_ifq #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .deq         (deq),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc4     (out_pc4),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: word at address a holds (a >> 2) + 0x100
    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a >> 2) + 32'h100;
    endfunction

    // Synchronous memory; returns garbage when not requested
    always @(posedge clock) begin
        imem_rdata <= imem_req ? memval(imem_addr) : 32'hDEAD_BEEF;
    end

    typedef struct packed {
        logic        rst;
        logic        rdr;
        logic [31:0] rpc;
        logic        dq;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                                input logic dq, input logic er, input logic [31:0] ea,
                                input logic eov, input logic [31:0] ei,
                                input logic [31:0] ep, input logic [2:0] ec);
        vec_t v;
        v.rst = r; v.rdr = rd; v.rpc = rpc; v.dq = dq;
        v.e_req = er; v.e_addr = ea; v.e_ov = eov;
        v.e_inst = ei; v.e_pc4 = ep; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        n_chk  = 0;
        n_fail = 0;

        //            rst   rdr   rpc           deq   req   addr          ov    inst          pc4           cnt
        vecs[0]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        3'd0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        3'd0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b0, 32'h0,        32'h0,        3'd0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        1'b1, 32'h100,      32'h4,        3'd1);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        1'b1, 32'h100,      32'h4,        3'd2);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h10,       1'b1, 32'h100,      32'h4,        3'd3);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h10,       1'b1, 32'h100,      32'h4,        3'd4);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       1'b1, 32'h100,      32'h4,        3'd4);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h14,       1'b1, 32'h101,      32'h8,        3'd3);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h18,       1'b1, 32'h102,      32'hC,        3'd3);
        vecs[10] = mk(1'b0, 1'b1, 32'h40,       1'b1, 1'b0, 32'h1C,       1'b1, 32'h103,      32'h10,       3'd3);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        32'h0,        3'd0);
        vecs[12] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h44,       1'b0, 32'h0,        32'h0,        3'd0);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h48,       1'b1, 32'h110,      32'h44,       3'd1);
        vecs[14] = mk(1'b0, 1'b1, 32'h43,       1'b1, 1'b0, 32'h4C,       1'b1, 32'h110,      32'h44,       3'd2);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       1'b0, 32'h0,        32'h0,        3'd0);
        vecs[16] = mk(1'b0, 1'b1, 32'hFFFFFFF8, 1'b1, 1'b0, 32'h44,       1'b0, 32'h0,        32'h0,        3'd0);
        vecs[17] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFF8, 1'b0, 32'h0,        32'h0,        3'd0);
        vecs[18] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        32'h0,        3'd0);
        vecs[19] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 32'h400000FE, 32'hFFFFFFFC, 3'd1);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1, 32'h400000FF, 32'h0,        3'd1);
        vecs[21] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        1'b1, 32'h100,      32'h4,        3'd1);
        vecs[22] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        1'b1, 32'h101,      32'h8,        3'd1);
        vecs[23] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h10,       1'b1, 32'h101,      32'h8,        3'd2);
        vecs[24] = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h14,       1'b1, 32'h101,      32'h8,        3'd3);
        vecs[25] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        3'd0);
        vecs[26] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b0, 32'h0,        32'h0,        3'd0);
        vecs[27] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        1'b1, 32'h100,      32'h4,        3'd1);

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        deq         = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Table: drive just after the edge, sample just before the next one
        for (int i = 0; i < NV; i++) begin
            reset       = vecs[i].rst;
            redirect    = vecs[i].rdr;
            redirect_pc = vecs[i].rpc;
            deq         = vecs[i].dq;
            #3;
            chk($sformatf("v%0d imem_req", i),  {31'h0, imem_req},  {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d imem_addr", i), imem_addr,          vecs[i].e_addr);
            chk($sformatf("v%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].e_ov});
            chk($sformatf("v%0d out_inst", i),  out_inst,           vecs[i].e_inst);
            chk($sformatf("v%0d out_pc4", i),   out_pc4,            vecs[i].e_pc4);
            chk($sformatf("v%0d count", i),     {29'h0, count},     {29'h0, vecs[i].e_cnt});
            @(posedge clock);
            #1;
        end

        // Redirect from steady streaming with a read in flight
        reset       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        deq         = 1'b1;
        @(posedge clock);
        #1;
        redirect    = 1'b0;
        first       = -1;
        for (int k = 1; k <= 8 && first < 0; k++) begin
            #3;
            if (k == 1) begin
                chk("redir count", {29'h0, count}, 32'h0);
                chk("redir out_valid", {31'h0, out_valid}, 32'h0);
                chk("redir imem_addr", imem_addr, 32'h200);
            end
            if (out_valid) begin
                first = k;
                chk("redir first inst", out_inst, 32'h180);
                chk("redir first pc4", out_pc4, 32'h204);
            end
            @(posedge clock);
            #1;
        end
        if (first < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL redir timeout: no valid output within 8 cycles, expected one at cycle 3");
        end else begin
            chk("redir latency", first, 32'd3);
        end
        #3;
        chk("redir second inst", out_inst, 32'h181);
        chk("redir second pc4", out_pc4, 32'h208);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
